// File: rtl/hms_clock_ctrl_if.sv
// hms_clock_ctrl_if: button inputs and time/display outputs of the
// time-of-day core, bundled for connection between the core and its user.
interface hms_clock_ctrl_if;
  logic       i_sw_mode;
  logic       i_sw_incr;
  logic [5:0] o_sec;
  logic [5:0] o_min;
  logic [4:0] o_hour;
  logic [1:0] o_mode;
  logic [2:0] o_blink;

  // User side: drives the buttons, reads the time.
  modport master (
    output i_sw_mode, i_sw_incr,
    input  o_sec, o_min, o_hour, o_mode, o_blink
  );

  // Core side: reads the buttons, drives the time.
  modport slave (
    input  i_sw_mode, i_sw_incr,
    output o_sec, o_min, o_hour, o_mode, o_blink
  );
endinterface

// File: rtl/hms_clock_ctrl.sv
// hms_clock_ctrl: time-of-day core. Derives a 1 Hz tick from clk, keeps
// hh:mm:ss, and lets two push-buttons (mode, increment) set the time.
// Optional macro DEBOUNCE_EN adds a DB_CYCLES stability filter per button;
// without it the synchronized button level is used directly.
module hms_clock_ctrl #(
  parameter int CLK_HZ    = 50000000,
  parameter int DB_CYCLES = 500000
) (
  input  logic         clk,
  input  logic         rst,
  hms_clock_ctrl_if.slave bus
);

  localparam int            CW        = $clog2(CLK_HZ);
  localparam logic [CW-1:0] TICK_LAST = CW'(CLK_HZ - 1);
  localparam logic [CW-1:0] HALF      = CW'(CLK_HZ / 2);

  // Refuse to elaborate with a tick period that cannot give a 50 % blink.
  if (CLK_HZ < 2 || (CLK_HZ % 2) != 0 || DB_CYCLES < 1) begin : g_bad_cfg
    $error("hms_clock_ctrl: CLK_HZ must be even and >= 2, DB_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    ST_CLOCK    = 2'd0,
    ST_SET_SEC  = 2'd1,
    ST_SET_MIN  = 2'd2,
    ST_SET_HOUR = 2'd3
  } state_t;

  // ---------------------------------------------------------------- input path
  // Bit 0 is the mode button, bit 1 the increment button.
  logic [1:0] btn_raw;
  logic [1:0] sync0_reg, sync1_reg;
  logic [1:0] filt_level;
  logic [1:0] filt_prev_reg;
  logic [1:0] pulse_reg;
  logic       mode_p, incr_p;

  assign btn_raw = {bus.i_sw_incr, bus.i_sw_mode};

  // Two-flop synchronizer for both asynchronous buttons.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync0_reg <= '0;
      sync1_reg <= '0;
    end else begin
      sync0_reg <= btn_raw;
      sync1_reg <= sync0_reg;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int             DBW     = $clog2(DB_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_debounce
    logic [DBW-1:0] db_cnt_reg;
    logic           db_level_reg;

    // Accept a new level only after it has differed for DB_CYCLES cycles.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        db_cnt_reg   <= '0;
        db_level_reg <= 1'b0;
      end else if (sync1_reg[gi] == db_level_reg) begin
        db_cnt_reg <= '0;
      end else if (db_cnt_reg == DB_LAST) begin
        db_level_reg <= sync1_reg[gi];
        db_cnt_reg   <= '0;
      end else begin
        db_cnt_reg <= db_cnt_reg + DBW'(1);
      end
    end

    assign filt_level[gi] = db_level_reg;
  end
`else
  assign filt_level = sync1_reg;
`endif

  // Registered rising-edge detect: one pulse per press, however long held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_prev_reg <= '0;
      pulse_reg     <= '0;
    end else begin
      filt_prev_reg <= filt_level;
      pulse_reg     <= filt_level & ~filt_prev_reg;
    end
  end

  assign mode_p = pulse_reg[0];
  assign incr_p = pulse_reg[1];

  // --------------------------------------------------------------- time core
  state_t        state_reg;
  logic [CW-1:0] tick_cnt_reg;
  logic [5:0]    sec_reg, min_reg;
  logic [4:0]    hour_reg;
  logic [2:0]    blink_reg;

  logic          tick;
  logic [CW-1:0] cnt_run_next;
  logic          phase_run;
  logic [5:0]    sec_inc, min_inc;
  logic [4:0]    hour_inc;

  assign tick         = (tick_cnt_reg == TICK_LAST);
  assign cnt_run_next = tick ? '0 : tick_cnt_reg + CW'(1);
  // Blink is derived from the next count so the registered mask lines up
  // with the count it describes.
  assign phase_run    = (cnt_run_next >= HALF);
  assign sec_inc      = (sec_reg  == 6'd59) ? 6'd0 : sec_reg  + 6'd1;
  assign min_inc      = (min_reg  == 6'd59) ? 6'd0 : min_reg  + 6'd1;
  assign hour_inc     = (hour_reg == 5'd23) ? 5'd0 : hour_reg + 5'd1;

  // Mode FSM, tick counter, time fields and blink mask, all registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_CLOCK;
      tick_cnt_reg <= '0;
      sec_reg      <= '0;
      min_reg      <= '0;
      hour_reg     <= '0;
      blink_reg    <= '0;
    end else begin
      tick_cnt_reg <= cnt_run_next;
      case (state_reg)
        ST_CLOCK: begin
          if (tick) begin
            sec_reg <= sec_inc;
            if (sec_reg == 6'd59) begin
              min_reg <= min_inc;
              if (min_reg == 6'd59) hour_reg <= hour_inc;
            end
          end
          if (mode_p) begin
            state_reg <= ST_SET_SEC;
            blink_reg <= {2'b00, phase_run};
          end else begin
            blink_reg <= 3'b000;
          end
        end
        ST_SET_SEC: begin
          if (mode_p) begin
            state_reg <= ST_SET_MIN;
            blink_reg <= {1'b0, phase_run, 1'b0};
          end else begin
            if (incr_p) sec_reg <= sec_inc;
            blink_reg <= {2'b00, phase_run};
          end
        end
        ST_SET_MIN: begin
          if (mode_p) begin
            state_reg <= ST_SET_HOUR;
            blink_reg <= {phase_run, 2'b00};
          end else begin
            if (incr_p) min_reg <= min_inc;
            blink_reg <= {1'b0, phase_run, 1'b0};
          end
        end
        ST_SET_HOUR: begin
          if (mode_p) begin
            // Restart the second so the first one after setting is whole.
            state_reg    <= ST_CLOCK;
            tick_cnt_reg <= '0;
            blink_reg    <= 3'b000;
          end else begin
            if (incr_p) hour_reg <= hour_inc;
            blink_reg <= {phase_run, 2'b00};
          end
        end
        default: begin
          state_reg <= ST_CLOCK;
          blink_reg <= 3'b000;
        end
      endcase
    end
  end

  assign bus.o_sec   = sec_reg;
  assign bus.o_min   = min_reg;
  assign bus.o_hour  = hour_reg;
  assign bus.o_mode  = state_reg;
  assign bus.o_blink = blink_reg;

endmodule

// File: tb/tb_hms_clock_ctrl.sv
// tb_hms_clock_ctrl: directed bench for hms_clock_ctrl with CLK_HZ=10,
// DB_CYCLES=4. Inputs change and outputs are sampled on the falling edge.
module tb_hms_clock_ctrl;
  localparam int CLK_HZ = 10;
  localparam int DB     = 4;
`ifdef DEBOUNCE_EN
  localparam int LAT     = 3 + DB;
  localparam int T5_HOLD = 10;
`else
  localparam int LAT     = 3;
  localparam int T5_HOLD = 1;
`endif
  localparam int HOLD = 6;
  localparam int GAP  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   clk_run = 1'b1;
  int   edges;
  int   base;
  int   errors, checks;
  int   es, em, eh;
  int   e_exit;

  hms_clock_ctrl_if bus ();

  hms_clock_ctrl #(.CLK_HZ(CLK_HZ), .DB_CYCLES(DB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  // Rising edges since reset release; the DUT tick count follows it.
  always @(posedge clk or posedge rst) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_time(input string tag);
    check({tag, " sec"},  32'(bus.o_sec),  32'(es));
    check({tag, " min"},  32'(bus.o_min),  32'(em));
    check({tag, " hour"}, 32'(bus.o_hour), 32'(eh));
  endtask

  function automatic logic [2:0] blink_exp(input int sel_bit);
    return (((edges - base) % CLK_HZ) >= CLK_HZ / 2) ? (3'b001 << sel_bit) : 3'b000;
  endfunction

  task automatic press(input logic m, input logic i);
    bus.i_sw_mode = m;
    bus.i_sw_incr = i;
    repeat (HOLD) @(negedge clk);
    bus.i_sw_mode = 1'b0;
    bus.i_sw_incr = 1'b0;
    repeat (GAP) @(negedge clk);
    $display("press mode=%0b incr=%0b -> %0d:%0d:%0d state=%0d",
             m, i, bus.o_hour, bus.o_min, bus.o_sec, bus.o_mode);
  endtask

  initial begin
    errors = 0; checks = 0; base = 0;
    bus.i_sw_mode = 1'b0;
    bus.i_sw_incr = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    es = 0; em = 0; eh = 0;
    check_time("reset");
    check("reset mode",  32'(bus.o_mode),  0);
    check("reset blink", 32'(bus.o_blink), 0);
    rst = 1'b0;

    // First tick at edge CLK_HZ, minute carry at edge 600
    repeat (9) @(negedge clk);
    check("t1 sec@9", 32'(bus.o_sec), 0);
    @(negedge clk);
    check("t1 sec@10",   32'(bus.o_sec),   1);
    check("t1 mode",     32'(bus.o_mode),  0);
    check("t1 blink",    32'(bus.o_blink), 0);
    repeat (589) @(negedge clk);
    es = 59; em = 0; eh = 0;
    check_time("t1 @599");
    @(negedge clk);
    es = 0; em = 1; eh = 0;
    check_time("t1 @600");

    // Held mode press: latency and a single pulse
    bus.i_sw_mode = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 19) bus.i_sw_mode = 1'b0;
      if (k == LAT - 1) check("t3 mode before", 32'(bus.o_mode), 0);
      if (k == LAT)     check("t3 mode after",  32'(bus.o_mode), 1);
    end
    repeat (GAP) @(negedge clk);
    check("t3 held one pulse", 32'(bus.o_mode), 1);
    check_time("t3 enter set");

    // Frozen seconds and blinking sec field
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      check("t3 frozen sec", 32'(bus.o_sec), 32'(es));
      check("t3 blink sec",  32'(bus.o_blink), 32'(blink_exp(0)));
    end

`ifdef DEBOUNCE_EN
    // A 3-cycle glitch must be rejected
    bus.i_sw_incr = 1'b1;
    repeat (3) @(negedge clk);
    bus.i_sw_incr = 1'b0;
    repeat (GAP + 4) @(negedge clk);
    check("t5 glitch", 32'(bus.o_sec), 32'(es));
`endif

    // Single increment with exact latency
    bus.i_sw_incr = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      if (k + 1 >= T5_HOLD) bus.i_sw_incr = 1'b0;
      if (k == LAT - 1) check("t5 incr before", 32'(bus.o_sec), 32'(es));
      if (k == LAT)     check("t5 incr after",  32'(bus.o_sec), 32'(es + 1));
    end
    es = es + 1;
    repeat (GAP) @(negedge clk);
    check("t5 incr single", 32'(bus.o_sec), 32'(es));

    // Seconds to 59, wrap with no carry, back to 59
    while (es != 59) begin press(1'b0, 1'b1); es++; end
    check_time("t4 sec 59");
    press(1'b0, 1'b1);
    es = 0;
    check_time("t4 sec wrap");
    while (es != 59) begin press(1'b0, 1'b1); es++; end

    // Simultaneous mode and incr: advance only
    press(1'b1, 1'b1);
    check("t4 mode+incr mode", 32'(bus.o_mode), 2);
    check_time("t4 mode+incr");
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("blink min", 32'(bus.o_blink), 32'(blink_exp(1)));
    end

    while (em != 59) begin press(1'b0, 1'b1); em++; end
    check_time("t2 min 59");
    press(1'b1, 1'b0);
    check("t2 mode hour", 32'(bus.o_mode), 3);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("blink hour", 32'(bus.o_blink), 32'(blink_exp(2)));
    end
    while (eh != 23) begin press(1'b0, 1'b1); eh++; end
    check_time("t2 23:59:59");

    // Leave SET_HOUR: full second, then full rollover in one edge
    bus.i_sw_mode = 1'b1;
    e_exit = edges + 1 + LAT;
    for (int k = 0; k <= LAT + 10; k++) begin
      @(negedge clk);
      if (k + 1 >= HOLD) bus.i_sw_mode = 1'b0;
      if (k == LAT - 1) check("t2 still hour", 32'(bus.o_mode), 3);
      if (k == LAT) begin
        check("t2 back to clock", 32'(bus.o_mode), 0);
        check("t2 blink off", 32'(bus.o_blink), 0);
        check_time("t2 exit");
      end
      if (k == LAT + 9) check_time("t2 @+9");
      if (k == LAT + 10) begin
        es = 0; em = 0; eh = 0;
        check_time("t2 rollover");
      end
    end
    base = e_exit;

    // Tick and mode pulse on the same edge in CLOCK
    repeat ((e_exit + 19 - LAT) - edges) @(negedge clk);
    bus.i_sw_mode = 1'b1;
    for (int k = 0; k <= LAT + 2; k++) begin
      @(negedge clk);
      if (k + 1 >= HOLD) bus.i_sw_mode = 1'b0;
      if (k == LAT - 1) begin
        check("tick+mode mode before", 32'(bus.o_mode), 0);
        check("tick+mode sec before",  32'(bus.o_sec),  0);
      end
      if (k == LAT) begin
        check("tick+mode mode", 32'(bus.o_mode),  1);
        check("tick+mode sec",  32'(bus.o_sec),   1);
        check("tick+mode blink", 32'(bus.o_blink), 0);
      end
    end
    bus.i_sw_mode = 1'b0;
    repeat (GAP) @(negedge clk);
    es = 1;

    // Asynchronous reset in SET_MIN with a press half-filtered
    press(1'b1, 1'b0);
    check("t6 in set min", 32'(bus.o_mode), 2);
    bus.i_sw_incr = 1'b1;
    repeat (2) @(negedge clk);
    clk_run = 1'b0;
    #2 rst = 1'b1;
    #1;
    es = 0; em = 0; eh = 0;
    check_time("t6 async reset");
    check("t6 async mode",  32'(bus.o_mode),  0);
    check("t6 async blink", 32'(bus.o_blink), 0);
    bus.i_sw_incr = 1'b0;
    #4 rst = 1'b0;
    #2 clk_run = 1'b1;
    repeat (9) @(negedge clk);
    check("t6 sec@9", 32'(bus.o_sec), 0);
    @(negedge clk);
    es = 1;
    check_time("t6 restart");
    check("t6 mode", 32'(bus.o_mode), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
